// File: rtl/tisaradc_rx.sv
// tisaradc_rx: 8-way TI-SAR-ADC receiver. Lane rotation, optional offset-binary to two's complement, FWFT frame FIFO
// with drop accounting. Define TISARADC_RX_CAL_EN to add the per-sub-ADC DC-mean calibration (cal_* ports).
module tisaradc_rx #(
  parameter int unsigned ADC_WAYS   = 8,
  parameter int unsigned ADC_BITS   = 9,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ACC_LOG2   = 10
) (
  input  logic                         clkrstP_s2,
  input  logic                         rst,
`ifdef TISARADC_RX_CAL_EN
  input  logic                         cal_start,
  output logic                         cal_busy,
  output logic                         cal_done,
  input  logic [2:0]                   cal_sel,
  output logic [ADC_BITS-1:0]          cal_mean,
`endif
  input  logic                         in_valid,
  input  logic [ADC_BITS-1:0]          adcout0,
  input  logic [ADC_BITS-1:0]          adcout1,
  input  logic [ADC_BITS-1:0]          adcout2,
  input  logic [ADC_BITS-1:0]          adcout3,
  input  logic [ADC_BITS-1:0]          adcout4,
  input  logic [ADC_BITS-1:0]          adcout5,
  input  logic [ADC_BITS-1:0]          adcout6,
  input  logic [ADC_BITS-1:0]          adcout7,
  input  logic [2:0]                   rot,
  input  logic                         twos_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADC_WAYS*ADC_BITS-1:0] out_data,
  output logic                         ovf,
  input  logic                         clr_ovf,
  output logic [7:0]                   drop_cnt
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FW    = ADC_WAYS * ADC_BITS;

  logic [ADC_BITS-1:0] raw [8];
  assign raw[0] = adcout0;
  assign raw[1] = adcout1;
  assign raw[2] = adcout2;
  assign raw[3] = adcout3;
  assign raw[4] = adcout4;
  assign raw[5] = adcout5;
  assign raw[6] = adcout6;
  assign raw[7] = adcout7;

  logic [FW-1:0] frame;
  always_comb begin
    frame = '0;
    for (int unsigned k = 0; k < ADC_WAYS; k++)
      frame[k*ADC_BITS +: ADC_BITS] = raw[3'(k) + rot] ^ {twos_en, {(ADC_BITS-1){1'b0}}};
  end

  logic [FW-1:0]    mem_q [FIFO_DEPTH];
  logic [FW-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [FW-1:0]    last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             empty, full, pop, push, drop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    pop      = !empty && out_ready;
    drop     = in_valid && full && !pop;
    push     = in_valid && !drop;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = frame;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // Holding the last popped head keeps out_data stable while the FIFO is empty.
    last_d = pop ? mem_q[rd_ptr_q] : last_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = clr_ovf ? 8'd1 : ((drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + 8'd1);
    end else if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clkrstP_s2 or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? last_q : mem_q[rd_ptr_q];
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef TISARADC_RX_CAL_EN
  localparam int unsigned ACC_W = ADC_BITS + ACC_LOG2;

  typedef enum logic [1:0] {CAL_IDLE, CAL_ACC, CAL_DONE} cal_state_e;
  cal_state_e          state_q, state_d;
  logic [ACC_W-1:0]    acc_q [8];
  logic [ACC_W-1:0]    acc_d [8];
  logic [ACC_LOG2-1:0] frm_q, frm_d;
  logic [ADC_BITS-1:0] mean_q [8];
  logic [ADC_BITS-1:0] mean_d [8];
  logic                last_frm;

  always_ff @(posedge clkrstP_s2 or posedge rst) begin
    if (rst) state_q <= CAL_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    last_frm = in_valid && (frm_q == '1);
    state_d  = state_q;
    unique case (state_q)
      CAL_IDLE: if (cal_start) state_d = CAL_ACC;
      CAL_ACC:  if (last_frm)  state_d = CAL_DONE;
      CAL_DONE: state_d = CAL_IDLE;
      default:  state_d = CAL_IDLE;
    endcase
  end

  always_comb begin
    cal_busy = (state_q == CAL_ACC);
    cal_done = (state_q == CAL_DONE);
    cal_mean = mean_q[cal_sel];
  end

  // Mean is taken from the sum including the final frame, so it latches on the ACC->DONE edge.
  always_comb begin
    acc_d  = acc_q;
    frm_d  = frm_q;
    mean_d = mean_q;
    if (state_q == CAL_IDLE && cal_start) begin
      acc_d = '{default: '0};
      frm_d = '0;
    end else if (state_q == CAL_ACC && in_valid) begin
      frm_d = frm_q + ACC_LOG2'(1);
      for (int unsigned n = 0; n < 8; n++) acc_d[n] = acc_q[n] + ACC_W'(raw[n]);
      if (last_frm)
        for (int unsigned n = 0; n < 8; n++) mean_d[n] = acc_d[n][ACC_LOG2 +: ADC_BITS];
    end
  end

  always_ff @(posedge clkrstP_s2 or posedge rst) begin
    if (rst) begin
      acc_q  <= '{default: '0};
      frm_q  <= '0;
      mean_q <= '{default: '0};
    end else begin
      acc_q  <= acc_d;
      frm_q  <= frm_d;
      mean_q <= mean_d;
    end
  end
`endif
endmodule

// File: tb/tb_tisaradc_rx.sv
// tb_tisaradc_rx: directed and randomized stimulus against a queue-based reference model of the receiver.
module tb_tisaradc_rx;
  localparam int W  = 8;
  localparam int B  = 9;
  localparam int D  = 4;
  localparam int AL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, twos_en, out_ready, clr_ovf, out_valid, ovf;
  logic [2:0]       rot;
  logic [B-1:0]     adc [W];
  logic [W*B-1:0]   out_data;
  logic [7:0]       drop_cnt;
`ifdef TISARADC_RX_CAL_EN
  logic             cal_start, cal_busy, cal_done;
  logic [2:0]       cal_sel;
  logic [B-1:0]     cal_mean;
`endif

  tisaradc_rx #(.ADC_WAYS(W), .ADC_BITS(B), .FIFO_DEPTH(D), .ACC_LOG2(AL)) dut (
    .clkrstP_s2(clk), .rst(rst),
`ifdef TISARADC_RX_CAL_EN
    .cal_start(cal_start), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_sel(cal_sel), .cal_mean(cal_mean),
`endif
    .in_valid(in_valid),
    .adcout0(adc[0]), .adcout1(adc[1]), .adcout2(adc[2]), .adcout3(adc[3]),
    .adcout4(adc[4]), .adcout5(adc[5]), .adcout6(adc[6]), .adcout7(adc[7]),
    .rot(rot), .twos_en(twos_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ovf(ovf), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W*B-1:0] got, input logic [W*B-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame queue, last shown head, sticky flag and drop count.
  logic [W*B-1:0] q [$];
  logic [W*B-1:0] m_last;
  bit             m_ovf;
  int             m_dc;
`ifdef TISARADC_RX_CAL_EN
  bit m_active, m_done;
  int m_frames;
  int m_sum  [8];
  int m_mean [8];
`endif

  function automatic logic [W*B-1:0] frame_of();
    logic [W*B-1:0] f;
    f = '0;
    for (int k = 0; k < W; k++) f[k*B +: B] = adc[(k + rot) % W] ^ (twos_en ? 9'h100 : 9'h000);
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last = '0;
    m_ovf  = 0;
    m_dc   = 0;
`ifdef TISARADC_RX_CAL_EN
    m_active = 0;
    m_done   = 0;
    m_frames = 0;
    for (int n = 0; n < 8; n++) begin m_sum[n] = 0; m_mean[n] = 0; end
`endif
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_data", out_data, (q.size() != 0) ? q[0] : m_last);
    chk("ovf", ovf, m_ovf);
    chk("drop_cnt", drop_cnt, m_dc);
`ifdef TISARADC_RX_CAL_EN
    chk("cal_busy", cal_busy, m_active);
    chk("cal_done", cal_done, m_done);
    chk("cal_mean", cal_mean, m_mean[cal_sel]);
`endif
  endtask

  task automatic model_update();
    bit pop, drop;
`ifdef TISARADC_RX_CAL_EN
    bit was_done;
`endif
    pop  = (q.size() != 0) && out_ready;
    drop = in_valid && (q.size() == D) && !pop;
    if (pop) m_last = q.pop_front();
    if (in_valid && !drop) q.push_back(frame_of());
    if (drop) begin
      m_ovf = 1;
      m_dc  = clr_ovf ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
    end else if (clr_ovf) begin
      m_ovf = 0;
      m_dc  = 0;
    end
`ifdef TISARADC_RX_CAL_EN
    was_done = m_done;
    m_done   = 0;
    if (m_active) begin
      if (in_valid) begin
        for (int n = 0; n < 8; n++) m_sum[n] += adc[n];
        m_frames++;
        if (m_frames == (1 << AL)) begin
          for (int n = 0; n < 8; n++) m_mean[n] = m_sum[n] / (1 << AL);
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (!was_done && cal_start) begin
      m_active = 1;
      m_frames = 0;
      for (int n = 0; n < 8; n++) m_sum[n] = 0;
    end
`endif
  endtask

  // Called at 1 time unit after a rising edge with inputs already driven.
  task automatic step();
    #3;
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; clr_ovf = 0; rot = '0; twos_en = 0;
    for (int n = 0; n < W; n++) adc[n] = '0;
`ifdef TISARADC_RX_CAL_EN
    cal_start = 0; cal_sel = '0;
`endif
  endtask

  task automatic rand_adc();
    for (int n = 0; n < W; n++) adc[n] = B'($urandom_range(0, 511));
  endtask

  // Asserted mid-cycle to exercise the asynchronous path.
  task automatic async_reset();
    #2;
    rst = 1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    chk("rst_out_data", out_data, '0);
    rst = 0;

    // Identity frame, one-cycle latency, then empty with data held.
    for (int n = 0; n < W; n++) adc[n] = B'(n * 16);
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    chk("lat_valid", out_valid, 1);
    for (int k = 0; k < W; k++) chk("lane_id", out_data[k*B +: B], k * 16);
    step();
    step();

    // Rotation by 3 with MSB inversion.
    adc[0] = 9'h100; adc[1] = 9'h000; adc[2] = 9'h1FF; adc[3] = 9'h0FF;
    adc[4] = 9'h101; adc[5] = 9'h002; adc[6] = 9'h180; adc[7] = 9'h07F;
    rot = 3'd3; twos_en = 1; in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    chk("rot_lane0", out_data[0 +: B], 9'h1FF);
    chk("rot_lane5", out_data[5*B +: B], 9'h000);
    out_ready = 1;
    step();
    step();
    rot = '0; twos_en = 0;

    // Six frames into a stalled FIFO: four stored, two dropped.
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      rand_adc(); in_valid = 1;
      step();
    end
    in_valid = 0;
    chk("ovf_after6", ovf, 1);
    chk("dc_after6", drop_cnt, 2);
    out_ready = 1;
    for (int i = 0; i < 5; i++) step();
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("ovf_clr", ovf, 0);
    chk("dc_clr", drop_cnt, 0);

    // Full FIFO with a simultaneous pop accepts the write.
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin rand_adc(); in_valid = 1; step(); end
    rand_adc(); in_valid = 1; out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
    chk("full_pop_dc", drop_cnt, 0);
    chk("full_pop_ovf", ovf, 0);
    step();
    // A drop beats a same-cycle clear.
    rand_adc(); in_valid = 1;
    step();
    clr_ovf = 1;
    step();
    clr_ovf = 0; in_valid = 0;
    chk("drop_wins_dc", drop_cnt, 1);
    chk("drop_wins_ovf", ovf, 1);

    // Drop counter saturation.
    in_valid = 1;
    for (int i = 0; i < 300; i++) begin rand_adc(); step(); end
    in_valid = 0;
    chk("dc_sat", drop_cnt, 255);
    clr_ovf = 1; out_ready = 1;
    step();
    clr_ovf = 0;

`ifdef TISARADC_RX_CAL_EN
    async_reset();
    idle();
    cal_start = 1;
    step();
    cal_start = 0;
    for (int i = 0; i < 4; i++) begin
      rand_adc(); adc[2] = B'(10 + i); in_valid = 1;
      cal_start = (i == 1);
      step();
    end
    in_valid = 0; cal_start = 0; cal_sel = 3'd2;
    chk("cal_done_pulse", cal_done, 1);
    chk("cal_mean_sel2", cal_mean, 11);
    step();
    chk("cal_done_low", cal_done, 0);

    cal_start = 1;
    step();
    cal_start = 0;
    for (int i = 0; i < 2; i++) begin rand_adc(); in_valid = 1; step(); end
    async_reset();
    in_valid = 0;
    chk("rst_cal_busy", cal_busy, 0);
    chk("rst_cal_done", cal_done, 0);
    chk("rst_cal_mean", cal_mean, 0);
    chk("rst_out_valid", out_valid, 0);
    step();
    step();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_adc();
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 50);
      clr_ovf   = ($urandom_range(0, 99) < 3);
      rot       = 3'($urandom_range(0, 7));
      twos_en   = $urandom_range(0, 1) != 0;
`ifdef TISARADC_RX_CAL_EN
      cal_start = ($urandom_range(0, 99) < 5);
      cal_sel   = 3'($urandom_range(0, 7));
`endif
      if ($urandom_range(0, 999) < 3) async_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
